// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming KxK convolution over a raster pixel stream.
// Pixels arrive over a valid/ready handshake, K-1 rows are kept in line
// buffers, and each valid window is reduced by a serial MAC (one tap per
// cycle) into a scaled, saturated, tagged result.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; coefficient writes accepted
//   LOAD   | accepting pixels until a window becomes valid or frame ends
//   MAC    | K*K cycles, one tap accumulated per cycle
//   SAT    | result register stage: scale, clamp and tag the accumulator
//   EMIT   | result presented, held until the consumer accepts it
//   DONE   | one-cycle end-of-frame pulse
module conv_stream_engine #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int K      = 4,
    parameter int STRIDE = 1,
    parameter int ACC_W  = 24,
    parameter int SHIFT  = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      done_o,
    input  logic                      coef_we_i,
    input  logic [$clog2(K*K)-1:0]    coef_idx_i,
    input  logic [DATA_W-1:0]         coef_data_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [DATA_W-1:0]         in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [DATA_W-1:0]         out_data_o,
    output logic [$clog2(IMG_H)-1:0]  out_row_o,
    output logic [$clog2(IMG_W)-1:0]  out_col_o
);

    localparam int NTAP = K * K;
    localparam int TW   = $clog2(NTAP);
    localparam int RW   = $clog2(IMG_H);
    localparam int CW   = $clog2(IMG_W);
    localparam int PW   = 2 * DATA_W + 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MAC, S_SAT, S_EMIT, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]        coef_q [NTAP];
    logic [DATA_W-1:0]        win_q  [NTAP];
    logic [DATA_W-1:0]        lb_q   [K-1][IMG_W];
    logic [RW-1:0]            row_q;
    logic [CW-1:0]            col_q;
    logic [TW-1:0]            tap_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [RW-1:0]            trig_row_q;
    logic [CW-1:0]            trig_col_q;
    logic                     last_q;
    logic [DATA_W-1:0]        out_data_q;
    logic [RW-1:0]            out_row_q;
    logic [CW-1:0]            out_col_q;

    logic                     xfer;
    logic                     last_pix;
    logic                     win_ok;
    logic [RW-1:0]            rel_row;
    logic [CW-1:0]            rel_col;
    logic [DATA_W-1:0]        col_v [K];
    logic signed [PW-1:0]     coef_x;
    logic signed [PW-1:0]     pix_x;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_sh;
    logic [DATA_W-1:0]        sat_val;

    assign xfer     = (state_q == S_LOAD) && in_valid_i;
    assign last_pix = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign rel_row  = row_q - RW'(K - 1);
    assign rel_col  = col_q - CW'(K - 1);
    assign win_ok   = (row_q >= RW'(K - 1)) && (col_q >= CW'(K - 1)) &&
                      ((int'(rel_row) % STRIDE) == 0) &&
                      ((int'(rel_col) % STRIDE) == 0);

    // New window column: oldest buffered row first, incoming pixel last
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            col_v[i] = lb_q[i][col_q];
        end
        col_v[K-1] = in_data_i;
    end

    // Signed coefficient times zero-extended pixel, then scale and clamp
    assign coef_x = PW'($signed(coef_q[tap_q]));
    assign pix_x  = PW'($signed({1'b0, win_q[tap_q]}));
    assign prod   = coef_x * pix_x;
    assign acc_sh = acc_q >>> SHIFT;

    // Clamp the scaled accumulator into the unsigned output range
    always_comb begin
        if (acc_sh[ACC_W-1]) begin
            sat_val = '0;
        end else if (acc_sh > SAT_MAX) begin
            sat_val = '1;
        end else begin
            sat_val = acc_sh[DATA_W-1:0];
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        done_o      = 1'b0;
        busy_o      = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready_o = 1'b1;
                if (xfer) begin
                    if (win_ok)        state_d = S_MAC;
                    else if (last_pix) state_d = S_DONE;
                end
            end
            S_MAC: begin
                if (tap_q == TW'(NTAP - 1)) state_d = S_SAT;
            end
            S_SAT: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = last_q ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Coefficient store, writable only while idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int n = 0; n < NTAP; n++) coef_q[n] <= '0;
        end else if ((state_q == S_IDLE) && coef_we_i && (int'(coef_idx_i) < NTAP)) begin
            coef_q[coef_idx_i] <= coef_data_i;
        end
    end

    // Line buffers and window shift on every accepted pixel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < K - 1; i++) begin
                for (int c = 0; c < IMG_W; c++) lb_q[i][c] <= '0;
            end
            for (int n = 0; n < NTAP; n++) win_q[n] <= '0;
        end else if (xfer) begin
            for (int i = 0; i < K - 1; i++) begin
                lb_q[i][col_q] <= col_v[i+1];
            end
            // Shift every row left; the rightmost column is overwritten below
            for (int n = 0; n < NTAP - 1; n++) begin
                win_q[n] <= win_q[n+1];
            end
            for (int i = 0; i < K; i++) begin
                win_q[i*K + K - 1] <= col_v[i];
            end
        end
    end

    // Raster position counters and the tag of the pixel that fired a window
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q      <= '0;
            col_q      <= '0;
            trig_row_q <= '0;
            trig_col_q <= '0;
            last_q     <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (xfer) begin
            trig_row_q <= rel_row;
            trig_col_q <= rel_col;
            last_q     <= last_pix;
            if (col_q == CW'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= last_pix ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    // Serial MAC: cleared when a window fires, one tap per MAC cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            tap_q <= '0;
        end else if (xfer && win_ok) begin
            acc_q <= '0;
            tap_q <= '0;
        end else if (state_q == S_MAC) begin
            acc_q <= acc_q + ACC_W'(prod);
            tap_q <= tap_q + TW'(1);
        end
    end

    // Result register, loaded once per window and held through EMIT
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q <= '0;
            out_row_q  <= '0;
            out_col_q  <= '0;
        end else if (state_q == S_SAT) begin
            out_data_q <= sat_val;
            out_row_q  <= trig_row_q;
            out_col_q  <= trig_col_q;
        end
    end

    assign out_data_o = out_data_q;
    assign out_row_o  = out_row_q;
    assign out_col_o  = out_col_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// Bench for conv_stream_engine: two instances (K=3, 6x6 image), one with
// stride 1 / no shift, one with stride 2 / shift 2. A direct 2-D convolution
// model produces the expected result list for each frame; one negedge
// process compares every presented result, tag and latency against it.
module tb_conv_stream_engine;

    localparam int K    = 3;
    localparam int W    = 6;
    localparam int H    = 6;
    localparam int NPIX = W * H;
    localparam int NTAP = K * K;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start     [2];
    logic       coef_we   [2];
    logic [3:0] coef_idx  [2];
    logic [7:0] coef_data [2];
    logic       in_valid  [2];
    logic [7:0] in_data   [2];
    logic       out_ready [2];
    logic       busy      [2];
    logic       done      [2];
    logic       in_ready  [2];
    logic       out_valid [2];
    logic [7:0] out_data  [2];
    logic [2:0] out_row   [2];
    logic [2:0] out_col   [2];

    always #5 clk = ~clk;

    conv_stream_engine #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(K), .STRIDE(1),
                         .ACC_W(24), .SHIFT(0)) u_s1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .busy_o(busy[0]),
        .done_o(done[0]), .coef_we_i(coef_we[0]), .coef_idx_i(coef_idx[0]),
        .coef_data_i(coef_data[0]), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
        .in_data_i(in_data[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
        .out_data_o(out_data[0]), .out_row_o(out_row[0]), .out_col_o(out_col[0]));

    conv_stream_engine #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(K), .STRIDE(2),
                         .ACC_W(24), .SHIFT(2)) u_s2 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .busy_o(busy[1]),
        .done_o(done[1]), .coef_we_i(coef_we[1]), .coef_idx_i(coef_idx[1]),
        .coef_data_i(coef_data[1]), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
        .in_data_i(in_data[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
        .out_data_o(out_data[1]), .out_row_o(out_row[1]), .out_col_o(out_col[1]));

    int n_cmp = 0;
    int n_err = 0;

    int coef_m   [2][NTAP];
    int pix_m    [2][NPIX];
    int exp_data [2][64];
    int exp_row  [2][64];
    int exp_col  [2][64];
    int exp_n    [2];
    int got_data [2][64];
    int got_row  [2][64];
    int got_col  [2][64];
    int got_n    [2];
    int xfer_cyc [2][NPIX];
    int xfer_n   [2];
    int done_cnt [2];
    bit prev_ov  [2];
    bit chk_en   [2];
    int ncyc = 0;

    function automatic void chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: plain 2-D convolution over every window the stride selects
    function automatic void build_exp(int d);
        int n, acc, stride, shift;
        stride = (d == 0) ? 1 : 2;
        shift  = (d == 0) ? 0 : 2;
        n = 0;
        for (int tr = 0; tr + K <= H; tr += stride) begin
            for (int tc = 0; tc + K <= W; tc += stride) begin
                acc = 0;
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        acc += coef_m[d][i*K+j] * pix_m[d][(tr+i)*W + tc + j];
                acc = acc >>> shift;
                if (acc < 0)   acc = 0;
                if (acc > 255) acc = 255;
                exp_data[d][n] = acc;
                exp_row[d][n]  = tr;
                exp_col[d][n]  = tc;
                n++;
            end
        end
        exp_n[d] = n;
    endfunction

    // crand: random coefficients, else all cval. pmode 0 const, 1 ramp, 2 random
    function automatic void fill(int d, int cval, bit crand, int pmode, int pval);
        for (int k = 0; k < NTAP; k++)
            coef_m[d][k] = crand ? int'($urandom_range(0, 255)) - 128 : cval;
        for (int p = 0; p < NPIX; p++)
            pix_m[d][p] = (pmode == 0) ? pval :
                          (pmode == 1) ? p : int'($urandom_range(0, 255));
    endfunction

    // Compare process: transfers, every presented result, latency, done
    always @(negedge clk) begin
        int k, tp;
        ncyc++;
        for (int d = 0; d < 2; d++) begin
            if (chk_en[d] && rst_n) begin
                if (in_valid[d] && in_ready[d]) begin
                    // transfer edge is the next posedge; index it by the following negedge
                    if (xfer_n[d] < NPIX) xfer_cyc[d][xfer_n[d]] = ncyc + 1;
                    xfer_n[d]++;
                end
                if (out_valid[d]) begin
                    k = got_n[d];
                    if (k >= exp_n[d]) begin
                        chk("extra_result", k, exp_n[d] - 1);
                    end else begin
                        chk("out_data", out_data[d], exp_data[d][k]);
                        chk("out_row", out_row[d], exp_row[d][k]);
                        chk("out_col", out_col[d], exp_col[d][k]);
                        chk("in_ready_in_emit", in_ready[d], 0);
                        if (!prev_ov[d]) begin
                            tp = (exp_row[d][k] + K - 1) * W + exp_col[d][k] + K - 1;
                            chk("latency", ncyc - xfer_cyc[d][tp], NTAP + 1);
                        end
                        if (out_ready[d]) begin
                            got_data[d][k] = out_data[d];
                            got_row[d][k]  = out_row[d];
                            got_col[d][k]  = out_col[d];
                            got_n[d]++;
                        end
                    end
                end
                if (done[d]) begin
                    done_cnt[d]++;
                    chk("done_after_last", got_n[d], exp_n[d]);
                end
                prev_ov[d] = out_valid[d] && !out_ready[d];
            end
        end
    end

    // mode 0 random valid, 2 always valid, 3 random valid plus ignored start/coef_we
    task automatic feed(int d, int mode);
        int  p = 0;
        int  budget = 0;
        bit  fire;
        while (p < NPIX && budget < 4000) begin
            in_data[d]  = 8'(pix_m[d][p]);
            in_valid[d] = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (mode == 3 && p == 8) begin
                start[d]     = 1'b1;
                coef_we[d]   = 1'b1;
                coef_idx[d]  = 4'd0;
                coef_data[d] = 8'd50;
            end
            @(negedge clk);
            fire = in_valid[d] && in_ready[d];
            @(posedge clk); #1;
            start[d]   = 1'b0;
            coef_we[d] = 1'b0;
            if (fire) p++;
            budget++;
        end
        in_valid[d] = 1'b0;
        if (p < NPIX) chk("feed_timeout", p, NPIX);
    endtask

    // mode 0 always ready, 1 random ready, 2 random ready after one 10-cycle hold
    task automatic consume(int d, int mode);
        int budget = 0;
        bit held = 0;
        int k0, x0;
        while (done_cnt[d] == 0 && budget < 4000) begin
            if (mode == 2 && !held && out_valid[d]) begin
                held = 1;
                k0 = got_n[d];
                x0 = xfer_n[d];
                out_ready[d] = 1'b0;
                repeat (10) begin
                    @(posedge clk); #1;
                    chk("hold_valid", out_valid[d], 1);
                    chk("hold_in_ready", in_ready[d], 0);
                    chk("hold_data", out_data[d], exp_data[d][k0]);
                    chk("hold_row", out_row[d], exp_row[d][k0]);
                    chk("hold_col", out_col[d], exp_col[d][k0]);
                end
                chk("hold_no_xfer", xfer_n[d], x0);
            end
            out_ready[d] = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            budget++;
        end
        out_ready[d] = 1'b0;
        if (done_cnt[d] == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic run_frame(int d, int fmode, int cmode, bit load_coef);
        if (load_coef) begin
            for (int k = 0; k < NTAP; k++) begin
                coef_we[d]   = 1'b1;
                coef_idx[d]  = 4'(k);
                coef_data[d] = 8'(coef_m[d][k]);
                @(posedge clk); #1;
            end
            coef_we[d] = 1'b0;
        end
        build_exp(d);
        got_n[d] = 0; xfer_n[d] = 0; done_cnt[d] = 0; prev_ov[d] = 0;
        for (int p = 0; p < NPIX; p++) xfer_cyc[d][p] = -1000;
        chk_en[d] = 1;
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        chk("busy_after_start", busy[d], 1);
        fork
            feed(d, fmode);
            consume(d, cmode);
        join
        repeat (3) @(posedge clk);
        #1;
        chk("result_count", got_n[d], exp_n[d]);
        chk("done_pulses", done_cnt[d], 1);
        chk("busy_idle", busy[d], 0);
        chk_en[d] = 0;
    endtask

    task automatic reset_test();
        int p = 0;
        int budget = 0;
        bit fire;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        // feed up to pixel (2,2), which fires the first window
        while (p < 2 * W + 3 && budget < 500) begin
            in_data[0]  = 8'(pix_m[0][p]);
            in_valid[0] = 1'b1;
            @(negedge clk);
            fire = in_valid[0] && in_ready[0];
            @(posedge clk); #1;
            if (fire) p++;
            budget++;
        end
        in_valid[0] = 1'b0;
        chk("rst_pre_feed", p, 2 * W + 3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pre_busy", busy[0], 1);
        chk("rst_pre_in_ready", in_ready[0], 0);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy[0], 0);
        chk("rst_done", done[0], 0);
        chk("rst_in_ready", in_ready[0], 0);
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_out_data", out_data[0], 0);
        chk("rst_out_row", out_row[0], 0);
        chk("rst_out_col", out_col[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; coef_we[d] = 0; coef_idx[d] = 0; coef_data[d] = 0;
            in_valid[d] = 0; in_data[d] = 0; out_ready[d] = 0;
            chk_en[d] = 0; got_n[d] = 0; xfer_n[d] = 0; done_cnt[d] = 0;
            exp_n[d] = 0; prev_ov[d] = 0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("init_busy", busy[d], 0);
            chk("init_done", done[d], 0);
            chk("init_in_ready", in_ready[d], 0);
            chk("init_out_valid", out_valid[d], 0);
            chk("init_out_data", out_data[d], 0);
            chk("init_out_row", out_row[d], 0);
            chk("init_out_col", out_col[d], 0);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // uniform frame, stride 1
        fill(0, 1, 0, 0, 1);
        run_frame(0, 0, 0, 1);
        chk("uniform_first_data", got_data[0][0], 9);
        chk("uniform_r1c0_row", got_row[0][4], 1);
        chk("uniform_r1c0_col", got_col[0][4], 0);
        chk("uniform_last_row", got_row[0][15], 3);
        chk("uniform_last_col", got_col[0][15], 3);
        chk("uniform_count", got_n[0], 16);

        // uniform frame, stride 2 and shift 2: sum 9 -> 2
        fill(1, 1, 0, 0, 1);
        run_frame(1, 0, 1, 1);
        chk("stride_count", got_n[1], 4);
        chk("stride_data", got_data[1][0], 2);
        chk("stride_t1_col", got_col[1][1], 2);
        chk("stride_t2_row", got_row[1][2], 2);
        chk("stride_t2_col", got_col[1][2], 0);
        chk("stride_t3_row", got_row[1][3], 2);
        chk("stride_t3_col", got_col[1][3], 2);

        // tap ordering: only tap 0 set, ramp pixels -> top-left pixel
        fill(0, 0, 0, 1, 0);
        coef_m[0][0] = 1;
        run_frame(0, 0, 1, 1);
        chk("taps_r1c1", got_data[0][5], 7);
        chk("taps_r3c3", got_data[0][15], 21);

        // all -1 coefficients clamp to 0
        fill(0, -1, 0, 2, 0);
        run_frame(0, 0, 1, 1);
        chk("neg_clamp", got_data[0][3], 0);

        // backpressure hold with a constantly offered pixel stream
        fill(0, 0, 1, 2, 0);
        run_frame(0, 2, 2, 1);

        // start and coef_we pulsed in LOAD must be ignored
        fill(0, 0, 1, 2, 0);
        run_frame(0, 3, 1, 1);

        // positive saturation
        fill(0, 127, 0, 0, 255);
        run_frame(0, 0, 1, 1);
        chk("sat_high", got_data[0][9], 255);

        // reset during MAC, then coefficients must read as cleared
        reset_test();
        fill(0, 0, 0, 2, 0);
        run_frame(0, 0, 1, 0);
        fill(0, 0, 1, 2, 0);
        run_frame(0, 0, 1, 1);

        // random frames on the stride/shift instance
        fill(1, 0, 1, 2, 0);
        run_frame(1, 0, 1, 1);
        fill(1, 0, 1, 2, 0);
        run_frame(1, 3, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
